// File: rtl/free_list_if.sv
// free_list_if: rename-stage <-> free-list handshake bundle.
// master = rename/commit side, slave = the free list itself.
interface free_list_if #(
    parameter int PW = 6,   // physical tag width
    parameter int CW = 6    // count width, clog2(PHYS-ARCH)+1
);
    logic          alloc_req;
    logic          alloc_ok;
    logic [PW-1:0] alloc_tag;
    logic          rel_valid;
    logic [PW-1:0] rel_tag;
    logic          ckpt_take;
    logic          restore_en;
    logic [CW-1:0] count;
    logic          empty;
    logic          err_overflow;
    logic          err_double_free;

    modport master (
        output alloc_req, rel_valid, rel_tag, ckpt_take, restore_en,
        input  alloc_ok, alloc_tag, count, empty, err_overflow, err_double_free
    );

    modport slave (
        input  alloc_req, rel_valid, rel_tag, ckpt_take, restore_en,
        output alloc_ok, alloc_tag, count, empty, err_overflow, err_double_free
    );
endinterface

// File: rtl/free_list.sv
// free_list: circular queue of free physical register tags for register renaming.
// Head hands out tags to rename, tail takes tags released at commit, and a single
// checkpoint of the head pointer lets mispredict recovery return every tag
// allocated since the checkpointed branch.
// Optional feature: define FREE_LIST_DFREE_CHECK_EN to add a free bitmap that
// flags releases of tags that are already free (err_double_free).
// DEPTH = PHYS-ARCH must be at least 2.
module free_list #(
    parameter int ARCH = 32,
    parameter int PHYS = 64,
    parameter int PW   = 6
) (
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave bus
);
    localparam int DEPTH = PHYS - ARCH;
    localparam int AW    = $clog2(DEPTH);
    localparam int PTRW  = AW + 1;

    // Storage and pointers. Pointer low bits index storage; the MSB toggles on
    // each wrap so equal low bits can be told apart as full or empty.
    logic [PW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   mem_d [DEPTH];
    logic [PW-1:0]   reset_tags [DEPTH];
    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [PTRW-1:0] ckpt_head_q, ckpt_head_d;
    logic            err_overflow_q, err_overflow_d;

    logic [PTRW-1:0] count_c;
    logic            empty_c;
    logic            full_c;
    logic            alloc_ok_c;
    logic            alloc_fire;
    logic            rel_fire;
    logic [PW-1:0]   head_tag;

    // Reset contents: entry i holds tag ARCH+i, i.e. every non-architectural tag is free.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reset_tags
            assign reset_tags[gi] = PW'(ARCH + gi);
        end
    endgenerate

    // Advance a pointer by one entry, wrapping at DEPTH and flipping the lap bit.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1)) begin
            return {~p[PTRW-1], {AW{1'b0}}};
        end
        return p + PTRW'(1);
    endfunction

    // Occupancy and handshake qualifiers derived from the pointers.
    always_comb begin
        if (head_q[PTRW-1] == tail_q[PTRW-1]) begin
            count_c = PTRW'(tail_q[AW-1:0]) - PTRW'(head_q[AW-1:0]);
        end else begin
            count_c = PTRW'(DEPTH) + PTRW'(tail_q[AW-1:0]) - PTRW'(head_q[AW-1:0]);
        end
        empty_c    = (count_c == '0);
        full_c     = (count_c == PTRW'(DEPTH));
        head_tag   = mem_q[head_q[AW-1:0]];
        // No bypass: a tag released this cycle can only be handed out next cycle.
        alloc_ok_c = !empty_c && !bus.restore_en;
        alloc_fire = bus.alloc_req && alloc_ok_c;
        rel_fire   = bus.rel_valid && !full_c;
    end

    // Next-state for storage, pointers, checkpoint and overflow flag.
    always_comb begin
        mem_d          = mem_q;
        head_d         = head_q;
        tail_d         = tail_q;
        ckpt_head_d    = ckpt_head_q;
        err_overflow_d = err_overflow_q | (bus.rel_valid && full_c);

        // Restore rewinds head, handing back everything allocated since the checkpoint.
        if (bus.restore_en) begin
            head_d = ckpt_head_q;
        end else if (alloc_fire) begin
            head_d = ptr_inc(head_q);
        end

        // Releases are applied even during a restore; they only touch the tail.
        if (rel_fire) begin
            mem_d[tail_q[AW-1:0]] = bus.rel_tag;
            tail_d                = ptr_inc(tail_q);
        end

        // Checkpoint captures head after this cycle's allocation, so that tag
        // stays with the older instructions. A restore in the same cycle wins.
        if (bus.ckpt_take && !bus.restore_en) begin
            ckpt_head_d = head_d;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q          <= reset_tags;
            head_q         <= '0;
            tail_q         <= {1'b1, {AW{1'b0}}};
            ckpt_head_q    <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            ckpt_head_q    <= ckpt_head_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign bus.alloc_ok     = alloc_ok_c;
    assign bus.alloc_tag    = head_tag;
    assign bus.count        = count_c;
    assign bus.empty        = empty_c;
    assign bus.err_overflow = err_overflow_q;

`ifdef FREE_LIST_DFREE_CHECK_EN
    // free_map: 1 = tag is currently free. alloc_since: tags allocated after the
    // checkpoint, which a restore marks free again.
    logic [PHYS-1:0] free_map_q, free_map_d;
    logic [PHYS-1:0] alloc_since_q, alloc_since_d;
    logic [PHYS-1:0] free_map_init;
    logic            err_double_free_q, err_double_free_d;

    generate
        for (gi = 0; gi < PHYS; gi++) begin : g_map_init
            assign free_map_init[gi] = (gi >= ARCH);
        end
    endgenerate

    // Bitmap bookkeeping; alloc and restore never fire together.
    always_comb begin
        free_map_d        = free_map_q;
        alloc_since_d     = alloc_since_q;
        err_double_free_d = err_double_free_q;

        if (bus.restore_en) begin
            free_map_d = free_map_q | alloc_since_q;
        end
        if (alloc_fire) begin
            free_map_d[head_tag]    = 1'b0;
            alloc_since_d[head_tag] = 1'b1;
        end
        if (rel_fire) begin
            if (free_map_q[bus.rel_tag]) begin
                err_double_free_d = 1'b1;
            end
            free_map_d[bus.rel_tag] = 1'b1;
        end
        // A tag allocated in the checkpoint cycle belongs before the checkpoint.
        if (bus.ckpt_take && !bus.restore_en) begin
            alloc_since_d = '0;
        end
    end

    // Bitmap registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_map_q        <= free_map_init;
            alloc_since_q     <= '0;
            err_double_free_q <= 1'b0;
        end else begin
            free_map_q        <= free_map_d;
            alloc_since_q     <= alloc_since_d;
            err_double_free_q <= err_double_free_d;
        end
    end

    assign bus.err_double_free = err_double_free_q;
`else
    assign bus.err_double_free = 1'b0;
`endif

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter ARCH, default 32, number of architectural registers.
REQ-002 SHALL have parameter PHYS, default 64, number of physical registers.
REQ-003 SHALL have parameter PW, default 6, physical tag width, with PHYS <= 2**PW.
REQ-004 SHALL have queue depth DEPTH = PHYS-ARCH and internal pointers of width clog2(DEPTH)+1.
REQ-005 clk  in  1  clock; all state updates on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 alloc_req  in  1  rename stage requests one destination tag this cycle.
REQ-008 alloc_ok  out  1  a tag is available; comb = !empty && !restore_en.
REQ-009 alloc_tag  out  PW  tag at queue head, valid when alloc_ok; drives rename-table prd_new.
REQ-010 rel_valid  in  1  commit releases one tag (the retired instruction's prd_old).
REQ-011 rel_tag  in  PW  tag being released.
REQ-012 ckpt_take  in  1  snapshot the allocation point for a branch.
REQ-013 restore_en  in  1  mispredict recovery; same-cycle pulse as the rename-table restore.
REQ-014 count  out  clog2(DEPTH)+1  number of free tags held.
REQ-015 empty  out  1  count == 0.
REQ-016 err_overflow  out  1  sticky; set when a release arrives while count == DEPTH.
REQ-017 err_double_free  out  1  sticky double-release flag (see Configuration).

Function
REQ-018 alloc_fire = alloc_req && alloc_ok; on fire, head advances by 1 (mod DEPTH) and alloc_tag shows the next entry next cycle.
REQ-019 rel_fire = rel_valid && count < DEPTH; on fire, rel_tag is written at tail and tail advances by 1 (mod DEPTH).
REQ-020 Release while count == DEPTH SHALL be dropped and SHALL set err_overflow.
REQ-021 Pointer wrap: the low bits index storage, the MSB distinguishes full from empty; count = tail - head using pointer width.
REQ-022 Simultaneous alloc_fire and rel_fire SHALL leave count unchanged; both take effect.
REQ-023 When empty, alloc_ok = 0 even if rel_valid is high the same cycle; the released tag is available the following cycle. There is no bypass.
REQ-024 ckpt_take SHALL load ckpt_head with the head value after any same-cycle alloc_fire, so that the tag allocated that cycle is older than the checkpoint.
REQ-025 A single checkpoint register SHALL exist; a new ckpt_take overwrites it.
REQ-026 restore_en SHALL set head <= ckpt_head, which returns all tags allocated since the checkpoint; count then follows from REQ-021.
REQ-027 A rel_fire in the same cycle as restore_en SHALL still be applied at tail.
REQ-028 ckpt_take in the same cycle as restore_en SHALL be ignored; restore wins.
REQ-029 Storage entries between ckpt_head and head SHALL never be overwritten before restore; this holds by count <= DEPTH and needs no extra logic.

Reset
REQ-030 On rst, storage entry i SHALL be loaded with tag ARCH+i for i = 0..DEPTH-1.
REQ-031 On rst, head = 0, tail = 0 with MSB = 1 (full), and ckpt_head = 0.
REQ-032 Resulting reset outputs: count = DEPTH, empty = 0, alloc_ok = 1, alloc_tag = ARCH, err_overflow = 0, err_double_free = 0.
REQ-033 rst asserted mid-operation SHALL override all same-cycle alloc, release, checkpoint and restore activity.

Configuration
REQ-034 Macro FREE_LIST_DFREE_CHECK_EN: when defined, SHALL maintain a free_map[PHYS] bitmap and an alloc_since[PHYS] mask.
- free_map reset: bits ARCH..PHYS-1 = 1; alloc_fire clears the allocated bit; rel_fire sets the released bit.
- alloc_since is cleared on ckpt_take and sets the bit of each alloc_fire.
- restore_en applies free_map |= alloc_since.
- A rel_fire whose tag bit is already 1 sets err_double_free.
REQ-035 When FREE_LIST_DFREE_CHECK_EN is not defined, err_double_free SHALL be tied 0 and no bitmap logic SHALL exist.

Verification
REQ-036 Reset then release rst -> count=32, alloc_ok=1, alloc_tag=32.
REQ-037 alloc_req held 32 cycles -> tags 32..63 in order; then empty=1, alloc_ok=0, count=0.
REQ-038 Empty; rel_valid with rel_tag=5 and alloc_req the same cycle -> no fire that cycle; next cycle alloc_tag=5, count=1.
REQ-039 After reset: alloc 3 (32,33,34), ckpt_take with a 4th alloc (35), alloc 36,37, then restore_en -> next cycle alloc_tag=36, count=28.
REQ-040 At count=32, rel_valid with rel_tag=7 -> dropped, err_overflow=1, count stays 32.
REQ-041 With the macro defined, rel_valid with rel_tag=40 while tag 40 is free -> err_double_free=1; without the macro, err_double_free stays 0.
